softmax_sched: RTL

//  Sequencer for the FP32 softmax datapath: buffers a vector of up to N IEEE-754 words and drives the shared
//  exp unit, sum accumulator and divider in phases. Emits exp(x_i)/sum_j exp(x_j) as a valid/ready stream.

---
 rtl/softmax_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/softmax_sched.sv
// Sequences the FP32 softmax datapath: buffer up to N words, exp phase with running sum, divide phase, stream out.
// Latency: about L (load) + L+EXP_LAT (exp) + 2 (sum) + L+DIV_LAT (div) cycles before the first output word.
// Backpressure: in_ready only in IDLE/LOAD; out_ready stalls OUT and holds out_data. SOFTMAX_PERF_CNT_EN adds perf_cyc.
module softmax_sched #(
    parameter int N       = 8,
    parameter int EXP_LAT = 4,
    parameter int DIV_LAT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        exp_vld,
    output logic [31:0] exp_x,
    input  logic [31:0] exp_y,
    output logic        acc_clr,
    output logic        acc_en,
    output logic [31:0] acc_d,
    input  logic [31:0] acc_sum,
    output logic        div_vld,
    output logic [31:0] div_num,
    output logic [31:0] div_den,
    input  logic [31:0] div_q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
`ifdef SOFTMAX_PERF_CNT_EN
    output logic [15:0] perf_cyc,
`endif
    output logic [1:0]  err
);
    localparam int AW = $clog2(N) + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXP, S_SUM, S_DIV, S_OUT} state_t;

    state_t          state, state_nxt;
    logic [31:0]     vec_buf [2**IW];
    logic [AW-1:0]   len;        // vector length; doubles as write pointer while loading
    logic [AW-1:0]   cnt;        // per-phase issue / output index, cleared on every state change
    logic [31:0]     den;
    logic [1:0]      err_q;
    logic            sum_wait;   // first SUM cycle lets the accumulator absorb the final addend
    logic [EXP_LAT-1:0] etag_vld;
    logic [AW-1:0]      etag_idx [EXP_LAT];
    logic [DIV_LAT-1:0] dtag_vld;
    logic [AW-1:0]      dtag_idx [DIV_LAT];
    logic            sum_zero;

    assign sum_zero = (acc_sum[30:0] == 31'd0);
    assign busy     = (state != S_IDLE);
    assign err      = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and output decode; data outputs are zero unless their strobe is high
    always_comb begin
        state_nxt = state;
        in_ready  = (state == S_IDLE) || (state == S_LOAD);
        exp_vld   = 1'b0;
        exp_x     = '0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        acc_d     = '0;
        div_vld   = 1'b0;
        div_num   = '0;
        div_den   = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state)
            S_IDLE: if (in_valid) state_nxt = (in_last || N == 1) ? S_EXP : S_LOAD;
            S_LOAD: if (in_valid && (in_last || len == LAST_IDX)) state_nxt = S_EXP;
            S_EXP: begin
                acc_clr = (cnt == '0);
                if (cnt < len) begin
                    exp_vld = 1'b1;
                    exp_x   = vec_buf[cnt[IW-1:0]];
                end
                if (etag_vld[EXP_LAT-1]) begin
                    acc_en = 1'b1;
                    acc_d  = exp_y;
                    if (etag_idx[EXP_LAT-1] == len - AW'(1)) state_nxt = S_SUM;
                end
            end
            S_SUM: if (sum_wait) state_nxt = sum_zero ? S_OUT : S_DIV;
            S_DIV: begin
                if (cnt < len) begin
                    div_vld = 1'b1;
                    div_num = vec_buf[cnt[IW-1:0]];
                    div_den = den;
                end
                if (dtag_vld[DIV_LAT-1] && dtag_idx[DIV_LAT-1] == len - AW'(1)) state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = vec_buf[cnt[IW-1:0]];
                out_last  = (cnt == len - AW'(1));
                if (out_ready && out_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control registers: tag pipes, counters, length, latched sum and sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            len      <= '0;
            cnt      <= '0;
            den      <= '0;
            err_q    <= 2'b00;
            sum_wait <= 1'b0;
            etag_vld <= '0;
            dtag_vld <= '0;
            for (int s = 0; s < EXP_LAT; s++) etag_idx[s] <= '0;
            for (int s = 0; s < DIV_LAT; s++) dtag_idx[s] <= '0;
        end else begin
            etag_vld[0] <= exp_vld;
            etag_idx[0] <= cnt;
            for (int s = 1; s < EXP_LAT; s++) begin
                etag_vld[s] <= etag_vld[s-1];
                etag_idx[s] <= etag_idx[s-1];
            end
            dtag_vld[0] <= div_vld;
            dtag_idx[0] <= cnt;
            for (int s = 1; s < DIV_LAT; s++) begin
                dtag_vld[s] <= dtag_vld[s-1];
                dtag_idx[s] <= dtag_idx[s-1];
            end
            sum_wait <= (state == S_SUM) && !sum_wait;
            if (state_nxt != state)
                cnt <= '0;
            else if (exp_vld || div_vld || (out_valid && out_ready))
                cnt <= cnt + AW'(1);
            case (state)
                S_IDLE: if (in_valid) begin
                    len   <= AW'(1);
                    err_q <= {1'b0, (!in_last && N == 1)};
                end
                S_LOAD: if (in_valid) begin
                    len <= len + AW'(1);
                    if (!in_last && len == LAST_IDX) err_q[0] <= 1'b1;
                end
                S_SUM: if (sum_wait) begin
                    den <= acc_sum;
                    if (sum_zero) err_q[1] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Vector buffer: loaded words, overwritten in place by exp results then quotients
    always_ff @(posedge clk) begin
        if (!rst) begin
            case (state)
                S_IDLE: if (in_valid) vec_buf[0] <= in_data;
                S_LOAD: if (in_valid) vec_buf[len[IW-1:0]] <= in_data;
                S_EXP:  if (etag_vld[EXP_LAT-1]) vec_buf[etag_idx[EXP_LAT-1][IW-1:0]] <= exp_y;
                S_SUM:  if (sum_wait && sum_zero) for (int m = 0; m < 2**IW; m++) vec_buf[m] <= '0;
                S_DIV:  if (dtag_vld[DIV_LAT-1]) vec_buf[dtag_idx[DIV_LAT-1][IW-1:0]] <= div_q;
                default: ;
            endcase
        end
    end

`ifdef SOFTMAX_PERF_CNT_EN
    logic [15:0] run_cnt;

    // Cycles since first input transfer; published at the final output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt  <= '0;
            perf_cyc <= '0;
        end else begin
            if (state == S_IDLE && in_valid)
                run_cnt <= 16'd1;
            else if (busy && run_cnt != 16'hFFFF)
                run_cnt <= run_cnt + 16'd1;
            if (state == S_OUT && out_ready && out_last)
                perf_cyc <= run_cnt;
        end
    end
`endif

endmodule
